// File: rtl/perf_counter_unit.sv
// perf_counter_unit: programmable event counters with a free-running cycle
// counter, sticky overflow flags and a shadow snapshot bank for readout.
module perf_counter_unit #(
  parameter  int NUM_CNT = 4,
  parameter  int CNT_W   = 32,
  parameter  int NUM_EV  = 8,
  localparam int IDX_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1,
  localparam int SEL_W   = $clog2(NUM_EV),
  localparam int RD_W    = $clog2(NUM_CNT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic [NUM_EV-1:0]  ev_i,
  input  logic               cfg_we_i,
  input  logic [IDX_W-1:0]   cfg_idx_i,
  input  logic [SEL_W-1:0]   cfg_sel_i,
  input  logic               cfg_sat_i,
  input  logic               clr_i,
  input  logic               snap_i,
  input  logic [RD_W-1:0]    rd_idx_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               snap_valid_o,
  output logic [NUM_CNT-1:0] ovf_o,
  output logic [CNT_W-1:0]   cycle_o
);

  logic [CNT_W-1:0]   cnt_q [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d [NUM_CNT];
  logic [SEL_W-1:0]   sel_q [NUM_CNT];
  logic [SEL_W-1:0]   sel_d [NUM_CNT];
  logic [NUM_CNT-1:0] sat_q, sat_d;
  logic [NUM_CNT-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  // Entries 0..NUM_CNT-1 hold event counters, entry NUM_CNT the cycle count.
  logic [CNT_W-1:0]   shd_q [NUM_CNT+1];
  logic [CNT_W-1:0]   shd_d [NUM_CNT+1];
  logic               snap_valid_q, snap_valid_d;

  // A select value beyond the last event line never matches (non power-of-two NUM_EV).
  function automatic logic ev_hit(input logic [NUM_EV-1:0] ev, input logic [SEL_W-1:0] sel);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < NUM_EV; j++) begin
      if (sel == SEL_W'(j)) begin
        hit = ev[j];
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

  // Next-state: counting uses the current (old) config, then cfg, snapshot and clear.
  always_comb begin
    cyc_d        = cyc_q;
    ovf_d        = ovf_q;
    sat_d        = sat_q;
    snap_valid_d = snap_valid_q;
    for (int k = 0; k < NUM_CNT; k++) begin
      cnt_d[k] = cnt_q[k];
      sel_d[k] = sel_q[k];
    end
    for (int k = 0; k <= NUM_CNT; k++) begin
      shd_d[k] = shd_q[k];
    end

    if (en_i) begin
      cyc_d = cyc_q + CNT_W'(1);
      for (int k = 0; k < NUM_CNT; k++) begin
        if (ev_hit(ev_i, sel_q[k])) begin
          if (cnt_q[k] == {CNT_W{1'b1}}) begin
            ovf_d[k] = 1'b1;
            if (sat_q[k]) begin
              cnt_d[k] = cnt_q[k];
            end else begin
              cnt_d[k] = {CNT_W{1'b0}};
            end
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
          end
        end else begin
          cnt_d[k] = cnt_q[k];
        end
      end
    end else begin
      cyc_d = cyc_q;
    end

    // Out-of-range indices match no counter and are therefore ignored.
    if (cfg_we_i) begin
      for (int k = 0; k < NUM_CNT; k++) begin
        if (cfg_idx_i == IDX_W'(k)) begin
          sel_d[k] = cfg_sel_i;
          sat_d[k] = cfg_sat_i;
        end else begin
          sel_d[k] = sel_d[k];
        end
      end
    end else begin
      sat_d = sat_d;
    end

    // Shadows take the pre-increment, pre-clear values of this cycle.
    if (snap_i) begin
      for (int k = 0; k < NUM_CNT; k++) begin
        shd_d[k] = cnt_q[k];
      end
      shd_d[NUM_CNT] = cyc_q;
      snap_valid_d   = 1'b1;
    end else begin
      snap_valid_d = snap_valid_d;
    end

    if (clr_i) begin
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt_d[k] = {CNT_W{1'b0}};
      end
      cyc_d        = {CNT_W{1'b0}};
      ovf_d        = {NUM_CNT{1'b0}};
      snap_valid_d = snap_i;
    end else begin
      cyc_d = cyc_d;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt_q[k] <= {CNT_W{1'b0}};
        sel_q[k] <= SEL_W'(k % NUM_EV);
      end
      for (int k = 0; k <= NUM_CNT; k++) begin
        shd_q[k] <= {CNT_W{1'b0}};
      end
      sat_q        <= {NUM_CNT{1'b0}};
      ovf_q        <= {NUM_CNT{1'b0}};
      cyc_q        <= {CNT_W{1'b0}};
      snap_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt_q[k] <= cnt_d[k];
        sel_q[k] <= sel_d[k];
      end
      for (int k = 0; k <= NUM_CNT; k++) begin
        shd_q[k] <= shd_d[k];
      end
      sat_q        <= sat_d;
      ovf_q        <= ovf_d;
      cyc_q        <= cyc_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  // Shadow read mux; indices above NUM_CNT read as zero.
  always_comb begin
    rd_data_o = {CNT_W{1'b0}};
    for (int k = 0; k <= NUM_CNT; k++) begin
      if (rd_idx_i == RD_W'(k)) begin
        rd_data_o = shd_q[k];
      end else begin
        rd_data_o = rd_data_o;
      end
    end
  end

  assign snap_valid_o = snap_valid_q;
  assign ovf_o        = ovf_q;
  assign cycle_o      = cyc_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Scoreboard bench for perf_counter_unit (NUM_CNT=4, CNT_W=8, NUM_EV=8).
module tb_perf_counter_unit;

  localparam int K_RD   = 0;
  localparam int K_CYC  = 1;
  localparam int K_OVF  = 2;
  localparam int K_SNAP = 3;

  typedef struct {
    int          kind;
    int          idx;
    logic [63:0] exp;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_i;
  logic [7:0] ev_i;
  logic       cfg_we_i;
  logic [1:0] cfg_idx_i;
  logic [2:0] cfg_sel_i;
  logic       cfg_sat_i;
  logic       clr_i;
  logic       snap_i;
  logic [2:0] rd_idx_i;
  logic [7:0] rd_data_o;
  logic       snap_valid_o;
  logic [3:0] ovf_o;
  logic [7:0] cycle_o;

  logic chk_req = 1'b0;
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  perf_counter_unit #(.NUM_CNT(4), .CNT_W(8), .NUM_EV(8)) dut (
    .clk(clk), .reset(reset), .en_i(en_i), .ev_i(ev_i),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_sel_i(cfg_sel_i),
    .cfg_sat_i(cfg_sat_i), .clr_i(clr_i), .snap_i(snap_i),
    .rd_idx_i(rd_idx_i), .rd_data_o(rd_data_o), .snap_valid_o(snap_valid_o),
    .ovf_o(ovf_o), .cycle_o(cycle_o)
  );

  always #5 clk = ~clk;

  // Monitor: whenever a check is presented, pop the expectation and compare.
  always @(negedge clk) begin
    if (chk_req) begin
      exp_t        e;
      logic [63:0] act;
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: no expectation queued");
      end else begin
        e = sb_q.pop_front();
        case (e.kind)
          K_RD:    act = 64'(rd_data_o);
          K_CYC:   act = 64'(cycle_o);
          K_OVF:   act = 64'(ovf_o);
          K_SNAP:  act = 64'(snap_valid_o);
          default: act = 64'hDEAD;
        endcase
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic quiet();
    en_i = 1'b0; ev_i = 8'h00; cfg_we_i = 1'b0; clr_i = 1'b0; snap_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic [7:0] ev);
    en_i = 1'b1; ev_i = ev;
    repeat (n) step();
    quiet();
  endtask

  task automatic do_snap(input logic clr);
    quiet(); snap_i = 1'b1; clr_i = clr;
    step();
    quiet();
  endtask

  task automatic do_clr();
    quiet(); clr_i = 1'b1;
    step();
    quiet();
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [2:0] sel, input logic sat);
    quiet(); cfg_we_i = 1'b1; cfg_idx_i = idx; cfg_sel_i = sel; cfg_sat_i = sat;
    step();
    quiet();
  endtask

  // Queue the expectation, then present the check to the monitor.
  task automatic chk(input int kind, input int idx, input logic [63:0] exp, input string name);
    exp_t e;
    e.kind = kind; e.idx = idx; e.exp = exp; e.name = name;
    sb_q.push_back(e);
    quiet();
    rd_idx_i = 3'(idx);
    chk_req  = 1'b1;
    @(negedge clk);
    #1 chk_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held while every strobe is active: reset must win.
    reset = 1'b0; en_i = 1'b1; ev_i = 8'hFF; snap_i = 1'b1; clr_i = 1'b0;
    cfg_we_i = 1'b1; cfg_idx_i = 2'd0; cfg_sel_i = 3'd5; cfg_sat_i = 1'b1;
    rd_idx_i = 3'd0;
    repeat (3) step();
    reset = 1'b1;
    quiet();
    chk(K_CYC, 0, 64'd0, "rst_cycle");
    chk(K_OVF, 0, 64'd0, "rst_ovf");
    chk(K_SNAP, 0, 64'd0, "rst_snap_valid");
    chk(K_RD, 0, 64'd0, "rst_shadow0");
    chk(K_RD, 4, 64'd0, "rst_shadow_cyc");

    // Ten retire events then snapshot (en_i low on the snap edge).
    run(10, 8'h01);
    do_snap(1'b0);
    chk(K_RD, 0, 64'd10, "basic_cnt0");
    chk(K_RD, 4, 64'd10, "basic_cyc_shadow");
    chk(K_RD, 1, 64'd0, "basic_cnt1");
    chk(K_SNAP, 0, 64'd1, "basic_snap_valid");
    chk(K_CYC, 0, 64'd10, "basic_cycle_live");
    chk(K_RD, 5, 64'd0, "rd_idx5_zero");
    chk(K_RD, 7, 64'd0, "rd_idx7_zero");

    // Disabled counting ignores all events.
    en_i = 1'b0; ev_i = 8'hFF;
    repeat (5) step();
    do_snap(1'b0);
    chk(K_RD, 0, 64'd10, "en0_cnt0");
    chk(K_RD, 2, 64'd0, "en0_cnt2");
    chk(K_CYC, 0, 64'd10, "en0_cycle");

    // Config write on the same edge as events: old selection counts that edge.
    en_i = 1'b1; ev_i = 8'h05; cfg_we_i = 1'b1; cfg_idx_i = 2'd2; cfg_sel_i = 3'd2; cfg_sat_i = 1'b0;
    step();
    cfg_we_i = 1'b0; ev_i = 8'h04; step();
    ev_i = 8'h08; cfg_we_i = 1'b1; cfg_idx_i = 2'd3; cfg_sel_i = 3'd0; step();
    cfg_we_i = 1'b0; ev_i = 8'h08; step();
    ev_i = 8'h01; step();
    do_snap(1'b0);
    chk(K_RD, 0, 64'd12, "cfg_cnt0");
    chk(K_RD, 2, 64'd2, "cfg_cnt2_same_sel");
    chk(K_RD, 3, 64'd2, "cfg_cnt3_old_then_new");
    chk(K_RD, 4, 64'd15, "cfg_cyc_shadow");

    // Clear alone drops snap_valid but keeps shadows.
    do_clr();
    chk(K_SNAP, 0, 64'd0, "clr_snap_valid");
    chk(K_RD, 0, 64'd12, "clr_shadow_kept");
    chk(K_CYC, 0, 64'd0, "clr_cycle");

    // Snapshot and clear together.
    run(7, 8'h01);
    do_snap(1'b1);
    chk(K_RD, 0, 64'd7, "snapclr_shadow0");
    chk(K_RD, 4, 64'd7, "snapclr_cyc_shadow");
    chk(K_CYC, 0, 64'd0, "snapclr_cycle_live");
    chk(K_SNAP, 0, 64'd1, "snapclr_snap_valid");
    do_clr();
    chk(K_SNAP, 0, 64'd0, "clr2_snap_valid");
    chk(K_RD, 0, 64'd7, "clr2_shadow0");
    do_snap(1'b0);
    chk(K_RD, 0, 64'd0, "snapclr_live0_cleared");
    chk(K_RD, 3, 64'd0, "snapclr_live3_cleared");

    // Wrap mode: counters 0 and 3 both select bit0.
    run(255, 8'h01);
    chk(K_OVF, 0, 64'd0, "wrap_no_ovf_at_ff");
    run(2, 8'h01);
    do_snap(1'b0);
    chk(K_RD, 0, 64'd1, "wrap_cnt0");
    chk(K_OVF, 0, 64'h9, "wrap_ovf");
    chk(K_CYC, 0, 64'd1, "wrap_cycle");

    // Saturate mode on counter1 selecting bit0.
    do_clr();
    cfg(2'd1, 3'd0, 1'b1);
    run(255, 8'h01);
    chk(K_OVF, 0, 64'd0, "sat_no_ovf_at_ff");
    run(1, 8'h01);
    chk(K_OVF, 0, 64'hB, "sat_ovf_set");
    run(44, 8'h01);
    do_snap(1'b0);
    chk(K_RD, 1, 64'hFF, "sat_cnt1_held");
    chk(K_RD, 0, 64'd44, "sat_cnt0_wrapped");
    chk(K_RD, 2, 64'd0, "sat_cnt2_idle");
    chk(K_RD, 4, 64'd44, "sat_cyc_shadow");
    run(5, 8'h01);
    do_snap(1'b0);
    chk(K_RD, 1, 64'hFF, "sat_cnt1_still_held");
    chk(K_OVF, 0, 64'hB, "ovf_sticky");
    do_clr();
    chk(K_OVF, 0, 64'd0, "ovf_cleared");

    // Reset mid-run discards everything and restores default selections.
    run(3, 8'hFF);
    do_snap(1'b0);
    en_i = 1'b1; ev_i = 8'hFF; reset = 1'b0;
    step();
    reset = 1'b1;
    quiet();
    chk(K_CYC, 0, 64'd0, "midrst_cycle");
    chk(K_OVF, 0, 64'd0, "midrst_ovf");
    chk(K_SNAP, 0, 64'd0, "midrst_snap_valid");
    chk(K_RD, 1, 64'd0, "midrst_shadow1");
    chk(K_RD, 4, 64'd0, "midrst_shadow_cyc");
    run(3, 8'h02);
    do_snap(1'b0);
    chk(K_RD, 1, 64'd3, "midrst_sel1_restored");
    chk(K_RD, 0, 64'd0, "midrst_sel0_restored");

    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_counter_unit.md
PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

Interface
REQ-001 SHALL have parameter NUM_CNT, default 4, number of programmable event counters (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, counter width in bits (8..64).
REQ-003 SHALL have parameter NUM_EV, default 8, number of event input lines (2..32).
REQ-004 SHALL have port clk, input, 1, clock; all state changes on rising edge.
REQ-005 SHALL have port reset, input, 1, reset, synchronous, active-low.
REQ-006 SHALL have port en_i, input, 1, global count enable; 0 freezes the cycle counter and all event counters.
REQ-007 SHALL have port ev_i, input, NUM_EV, per-cycle event pulses: bit0 retire, bit1 branch, bit2 mispredict flush, bit3 stall; remaining bits user-defined.
REQ-008 SHALL have port cfg_we_i, input, 1, configuration write strobe.
REQ-009 SHALL have port cfg_idx_i, input, clog2(NUM_CNT) (min 1), counter selected for configuration.
REQ-010 SHALL have port cfg_sel_i, input, clog2(NUM_EV), event index assigned to that counter.
REQ-011 SHALL have port cfg_sat_i, input, 1, counter mode: 0 wrap, 1 saturate.
REQ-012 SHALL have port clr_i, input, 1, synchronous clear of all counters, cycle counter and overflow flags.
REQ-013 SHALL have port snap_i, input, 1, capture all live counts into shadow registers.
REQ-014 SHALL have port rd_idx_i, input, clog2(NUM_CNT+1), shadow read select; value NUM_CNT selects the shadow cycle count.
REQ-015 SHALL have port rd_data_o, output, CNT_W, selected shadow value, combinational from rd_idx_i.
REQ-016 SHALL have port snap_valid_o, output, 1, shadow registers hold a valid snapshot.
REQ-017 SHALL have port ovf_o, output, NUM_CNT, sticky per-counter overflow flags.
REQ-018 SHALL have port cycle_o, output, CNT_W, live cycle count.

Function
REQ-019 Cycle counter SHALL increment by 1 on every edge with en_i=1; it always wraps and has no overflow flag.
REQ-020 Counter k SHALL increment by 1 on an edge where en_i=1 and ev_i[sel_k]=1; otherwise it holds.
REQ-021 Wrap mode: at all-ones, the increment SHALL produce 0 and set ovf_o[k] on the same edge.
REQ-022 Saturate mode: at all-ones, the counter SHALL hold all-ones and set ovf_o[k]; no further change until clear.
REQ-023 ovf_o bits SHALL be sticky and cleared only by clr_i or reset.
REQ-024 cfg_we_i SHALL update sel_k and mode_k of counter cfg_idx_i on the edge, without changing its count; cfg_idx_i >= NUM_CNT SHALL be ignored.
REQ-025 An event arriving on the same edge as a cfg write SHALL be counted under the old configuration; the new configuration applies from the next edge.
REQ-026 clr_i SHALL zero all counters, the cycle counter and ovf_o on the edge, taking priority over increments in that cycle.
REQ-027 snap_i SHALL copy all counters and the cycle counter (pre-increment values of that cycle) into shadows on the edge and set snap_valid_o.
REQ-028 With snap_i and clr_i together, shadows SHALL capture the pre-clear values, live state SHALL clear, and snap_valid_o SHALL be 1.
REQ-029 When clr_i is asserted without snap_i, snap_valid_o SHALL be cleared; shadow contents SHALL be retained.
REQ-030 rd_idx_i > NUM_CNT SHALL return rd_data_o=0.
REQ-031 Snapshot and cycle capture SHALL operate regardless of en_i.

Reset
REQ-032 While reset=0 at an edge, all counters, shadows and the cycle counter SHALL be 0, ovf_o=0, snap_valid_o=0.
REQ-033 Reset SHALL set sel_k = k mod NUM_EV and mode_k = wrap.
REQ-034 Reset SHALL override clr_i, snap_i and cfg_we_i in the same cycle; reset mid-count SHALL discard all state.

Verification
REQ-035 Defaults, reset released, en_i=1, ev_i=8'h01 for 10 cycles, snap_i, rd_idx_i=0 -> rd_data_o=10; rd_idx_i=4 -> rd_data_o=10.
REQ-036 CNT_W=8, counter0 in wrap mode, preloaded to 8'hFE by counting 254 events, then 3 events -> count 1, ovf_o[0]=1.
REQ-037 CNT_W=8, counter1 configured to sel=0 and saturate, then 300 events -> count 8'hFF, ovf_o[1]=1, held at 8'hFF.
REQ-038 cfg_we_i with cfg_idx_i=2 and cfg_sel_i=2 on the same edge as ev_i=8'h05 -> counter2 increments once under old sel=2; the following ev_i=8'h04 also counts.
REQ-039 Counter0 at 7, snap_i and clr_i together -> shadow0=7, live counter0=0, snap_valid_o=1; next clr_i alone -> snap_valid_o=0, shadow0 still 7.
REQ-040 en_i=0 with ev_i=8'hFF for 5 cycles -> counters and cycle_o unchanged; reset=0 mid-run -> all outputs 0 on the next edge.
